// File: rtl/load_store_unit_if.sv
// Bundle of the CPU request/response handshakes and the data memory port.
// master = CPU + memory side, slave = load_store_unit.
interface load_store_unit_if #(
    parameter int M = 10
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [M+1:0]     req_addr;
    logic [31:0]      req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_rdata;
    logic             resp_err;
    logic [M+1:0]     mem_address;
    logic [31:0]      mem_mask;
    logic [31:0]      mem_w;
    logic [31:0]      mem_v;

    modport master (
        output req_valid, req_we, req_size, req_unsigned,
        output req_addr, req_wdata, resp_ready, mem_v,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_mask, mem_w
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned,
        input  req_addr, req_wdata, resp_ready, mem_v,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_mask, mem_w
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word access to a big-endian byte memory
// with a 1-cycle registered read and a per-bit write mask.
module load_store_unit #(
    parameter int M = 10
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DATA   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]   state_q, state_d;
    logic         we_q, we_d;
    logic [1:0]   size_q, size_d;
    logic         uns_q, uns_d;
    logic [M+1:0] addr_q, addr_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         err_q, err_d;
    logic [31:0]  mask_q, mask_d;
    logic [31:0]  w_q, w_d;
    logic         misaligned;

    // Byte lanes a store touches; the target byte sits in [31:24].
    function automatic logic [31:0] lane_mask(input logic [1:0] sz);
        logic [31:0] m;
        unique case (sz)
            2'd0:    m = 32'hFF00_0000;
            2'd1:    m = 32'hFFFF_0000;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    // Left-justify right-justified store data into the lanes.
    function automatic logic [31:0] lane_data(input logic [1:0] sz,
                                              input logic [31:0] d);
        logic [31:0] r;
        unique case (sz)
            2'd0:    r = {d[7:0], 24'h0};
            2'd1:    r = {d[15:0], 16'h0};
            default: r = d;
        endcase
        return r;
    endfunction

    // Right-justify and extend the leading bytes of a memory read.
    function automatic logic [31:0] extend(input logic [31:0] v,
                                           input logic [1:0] sz,
                                           input logic u);
        logic        s;
        logic [31:0] r;
        s = ~u & v[31];
        unique case (sz)
            2'd0:    r = {{24{s}}, v[31:24]};
            2'd1:    r = {{16{s}}, v[31:16]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Alignment/size check on the incoming request.
    always_comb begin
        misaligned = 1'b0;
        unique case (bus.req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = bus.req_addr[0];
            2'd2:    misaligned = |bus.req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Next-state and datapath: mask is only ever set for one cycle.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mask_d  = 32'h0;
        w_d     = w_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr;
                    rdata_d = 32'h0;
                    err_d   = misaligned;
                    if (misaligned) begin
                        state_d = RESP;
                    end else begin
                        state_d = ACCESS;
                        if (bus.req_we) begin
                            mask_d = lane_mask(bus.req_size);
                            w_d    = lane_data(bus.req_size,
                                               bus.req_wdata);
                        end
                    end
                end
            end
            ACCESS: begin
                state_d = we_q ? RESP : DATA;
            end
            DATA: begin
                rdata_d = extend(bus.mem_v, size_q, uns_q);
                state_d = RESP;
            end
            default: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and output registers; reset clears the mask immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            mask_q  <= 32'h0;
            w_q     <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            w_q     <= w_d;
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.resp_valid  = (state_q == RESP);
    assign bus.resp_rdata  = rdata_q;
    assign bus.resp_err    = err_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_mask    = mask_q;
    assign bus.mem_w       = w_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-array model.
// Includes the big-endian memory the unit drives.
module tb_load_store_unit;
    localparam int M    = 10;
    localparam int MEMB = 4 << M;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  dmem    [0:MEMB-1];
    logic [7:0]  ref_mem [0:MEMB-1];
    logic [31:0] rd_word;

    load_store_unit_if #(.M(M)) bus ();

    load_store_unit #(.M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Data memory: registered read of addr..addr+3, masked write each clock.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            int idx;
            idx = (int'(bus.mem_address) + i) % MEMB;
            rd_word[31-8*i -: 8] = dmem[idx];
            dmem[idx] <= (dmem[idx] & ~bus.mem_mask[31-8*i -: 8])
                       | (bus.mem_w[31-8*i -: 8] & bus.mem_mask[31-8*i -: 8]);
        end
        bus.mem_v <= rd_word;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 1);
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 0);
        check({tag, "_rdata"}, bus.resp_rdata, 0);
        check({tag, "_err"}, 32'(bus.resp_err), 0);
        check({tag, "_addr"}, 32'(bus.mem_address), 0);
        check({tag, "_mask"}, bus.mem_mask, 0);
        check({tag, "_w"}, bus.mem_w, 0);
    endtask

    task automatic xact(input logic we, input logic [1:0] size,
                        input logic uns, input logic [11:0] addr,
                        input logic [31:0] wdata, input int hold);
        int          n, lat, exp_lat, mcyc, exp_mcyc;
        bit          mis;
        logic [31:0] exp_rd, exp_mask, exp_w, got_rd;
        logic        got_err;
        n   = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        mis = (size == 3) || (size == 1 && addr % 2 != 0)
           || (size == 2 && addr % 4 != 0);
        exp_rd = 0;
        if (!mis && !we) begin
            for (int i = 0; i < n; i++)
                exp_rd = (exp_rd << 8) | 32'(ref_mem[(addr + i) % MEMB]);
            if (!uns && n < 4 && exp_rd[8*n-1])
                exp_rd = exp_rd | (32'hFFFF_FFFF << (8 * n));
        end
        exp_lat  = mis ? 1 : (we ? 2 : 3);
        exp_mcyc = (!mis && we) ? 1 : 0;
        exp_mask = 32'hFFFF_FFFF << (32 - 8 * n);
        exp_w    = wdata << (32 - 8 * n);

        @(negedge clk);
        check("req_ready_idle", 32'(bus.req_ready), 1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        lat  = 0;
        mcyc = 0;
        while (1) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            lat++;
            if (bus.mem_mask != 0) begin
                mcyc++;
                check("st_mask", bus.mem_mask, exp_mask);
                check("st_wdata", bus.mem_w, exp_w);
                check("st_addr", 32'(bus.mem_address), 32'(addr));
            end
            if (bus.resp_valid) break;
            if (bus.req_ready) check("busy_ready", 32'(bus.req_ready), 0);
            if (lat >= 10) begin
                check("resp_timeout", 32'(lat), 32'(exp_lat));
                return;
            end
        end
        if (!mis && we)
            for (int i = 0; i < n; i++)
                ref_mem[(addr + i) % MEMB] = wdata[8*(n-1-i) +: 8];
        check("latency", 32'(lat), 32'(exp_lat));
        check("mask_cycles", 32'(mcyc), 32'(exp_mcyc));
        check("rdata", bus.resp_rdata, exp_rd);
        check("err", 32'(bus.resp_err), 32'(mis));
        check("addr_held", 32'(bus.mem_address), 32'(addr));
        check("resp_ready_lo", 32'(bus.req_ready), 0);
        got_rd  = bus.resp_rdata;
        got_err = bus.resp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            bus.req_valid = h[0];
            bus.req_we    = $urandom_range(0, 1);
            bus.req_addr  = 12'($urandom);
            check("bp_valid", 32'(bus.resp_valid), 1);
            check("bp_rdata", bus.resp_rdata, got_rd);
            check("bp_err", 32'(bus.resp_err), 32'(got_err));
            check("bp_ready", 32'(bus.req_ready), 0);
            check("bp_mask", bus.mem_mask, 0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("post_valid", 32'(bus.resp_valid), 0);
        check("post_ready", 32'(bus.req_ready), 1);
    endtask

    initial begin
        for (int i = 0; i < MEMB; i++) begin
            dmem[i]    = 8'h0;
            ref_mem[i] = 8'h0;
        end
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = 32'h0;
        bus.resp_ready   = 1'b0;
        bus.mem_v        = 32'h0;
        rd_word          = 32'h0;
        #12;
        check_reset_vals("rst0");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("idle0");

        // Word round trip, byte/half extraction, byte overwrite.
        xact(1, 2, 0, 12'h010, 32'h1122_3344, 0);
        xact(0, 2, 0, 12'h010, 32'h0, 0);
        xact(0, 0, 1, 12'h013, 32'h0, 0);
        xact(0, 1, 0, 12'h012, 32'h0, 0);
        xact(1, 0, 0, 12'h011, 32'hFFFF_FFA5, 0);
        xact(0, 2, 0, 12'h010, 32'h0, 0);
        // Sign extension.
        xact(1, 2, 0, 12'h020, 32'h80FF_7F01, 0);
        xact(0, 0, 0, 12'h020, 32'h0, 0);
        xact(0, 0, 1, 12'h020, 32'h0, 0);
        xact(0, 1, 0, 12'h020, 32'h0, 0);
        xact(0, 1, 0, 12'h022, 32'h0, 0);
        // Errors, then memory at 0x020 must be untouched.
        xact(0, 1, 0, 12'h021, 32'h0, 0);
        xact(1, 2, 0, 12'h022, 32'h5555_5555, 0);
        xact(1, 3, 0, 12'h000, 32'h5555_5555, 0);
        xact(0, 2, 0, 12'h020, 32'h0, 0);
        // Backpressure on a load.
        xact(0, 2, 0, 12'h010, 32'h0, 5);

        // Reset during a store's ACCESS cycle.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_addr  = 12'h030;
        bus.req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("rst_pre_mask", bus.mem_mask, 32'hFFFF_FFFF);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_no_resp", 32'(bus.resp_valid), 0);
        end
        xact(0, 2, 0, 12'h030, 32'h0, 0);

        // Randomized traffic in a small window so loads hit stored data.
        for (int t = 0; t < 150; t++) begin
            xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 12'($urandom_range(0, 127)),
                 $urandom, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
